ahb_req_arbiter: RTL and testbench

AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

---
 rtl/ahb_arb_pkg.sv | 17 +
 rtl/ahb_rr_pick.sv | 39 +++
 rtl/ahb_req_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
//   Shared definitions for the AHB request arbiter slice: FSM state type and
//   encodings, the maximum supported requester count and the grant index width.
//   Imported by ahb_rr_pick and ahb_req_arbiter.
package ahb_arb_pkg;

  localparam int unsigned NUM_REQ_MAX = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_REQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick
//   Combinational round-robin pick: starting one past the last granted index
//   (wrapping modulo NUM_REQ), return the first asserted request.
// Ports:
//   req_i   in  NUM_REQ  request vector
//   last_i  in  IDX_W    index granted last time
//   any_o   out 1        at least one request asserted
//   gnt_o   out NUM_REQ  one-hot grant (0 when any_o is low)
//   idx_o   out IDX_W    index of the granted requester
module ahb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    any_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    // Outer loop walks priority order (nearest after last_i first); the inner
    // loop keeps every bit select at a constant index.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_o && req_i[i] && (i == (32'(last_i) + off) % NUM_REQ)) begin
          any_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter
//   Round-robin arbiter putting up to NUM_REQ (2..4) requesters onto a single
//   AHB master request interface, one transfer at a time
//   (IDLE -> ISSUE -> WAIT -> RESP -> IDLE).
// Optional feature: define AHB_ARB_ERR_CNT_EN to add the 8-bit saturating
//   err_count output counting responses that carried m_error_flag.
// Ports:
//   HCLK, HRESETn                       clock, async active-low reset
//   req_valid/req_write [NUM_REQ]       per-requester request and direction
//   req_addr/req_wdata  packed          requester i at slice i
//   req_ready [NUM_REQ]                 one-hot acceptance pulse
//   rsp_valid [NUM_REQ]                 one-hot completion pulse
//   rsp_rdata, rsp_error                shared response, qualified by rsp_valid
//   busy                                high whenever the FSM is not IDLE
//   m_request_write/read                single-cycle strobes to the master
//   m_write_addr/m_read_addr            latched transfer address
//   m_write_data                        latched write data
//   m_read_data, m_error_flag           master read data and error status
//   HREADY                              AHB bus ready
//   err_count [8]                       (AHB_ARB_ERR_CNT_EN only)
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_error,
  output logic                            busy,
  output logic                            m_request_write,
  output logic                            m_request_read,
  output logic [ADDR_WIDTH-1:0]           m_write_addr,
  output logic [ADDR_WIDTH-1:0]           m_read_addr,
  output logic [DATA_WIDTH-1:0]           m_write_data,
  input  logic [DATA_WIDTH-1:0]           m_read_data,
  input  logic                            m_error_flag,
  input  logic                            HREADY
`ifdef AHB_ARB_ERR_CNT_EN
  ,
  output logic [7:0]                      err_count
`endif
);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    mwr_q, mwr_d;
  logic                    mrd_q, mrd_d;
  logic [NUM_REQ-1:0]      smp_vld_q, smp_vld_d;
  logic [DATA_WIDTH-1:0]   smp_rdata_q, smp_rdata_d;
  logic                    smp_err_q, smp_err_d;
  logic [NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
`ifdef AHB_ARB_ERR_CNT_EN
  logic [7:0]              err_cnt_q, err_cnt_d;
`endif

  logic                    pick_any;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;

  ahb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .any_o  (pick_any),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = '0;
    mwr_d       = 1'b0;
    mrd_d       = 1'b0;
    smp_vld_d   = '0;
    smp_rdata_d = '0;
    smp_err_d   = 1'b0;
    // The response is captured in RESP and presented one edge later, so the
    // completion pulse lands four edges after acceptance with HREADY high.
    rsp_vld_d   = smp_vld_q;
    rsp_rdata_d = smp_rdata_q;
    rsp_err_d   = smp_err_q;
`ifdef AHB_ARB_ERR_CNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ISSUE;
          last_d  = pick_idx;
          gnt_d   = pick_gnt;
          ready_d = pick_gnt;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              wr_d    = req_write[i];
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          // Strobes are registered on entry so they are high exactly in ISSUE.
          mwr_d = wr_d;
          mrd_d = !wr_d;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (HREADY) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        smp_vld_d   = gnt_q;
        smp_rdata_d = wr_q ? '0 : m_read_data;
        smp_err_d   = m_error_flag;
`ifdef AHB_ARB_ERR_CNT_EN
        if (m_error_flag && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= '0;
      mwr_q       <= 1'b0;
      mrd_q       <= 1'b0;
      smp_vld_q   <= '0;
      smp_rdata_q <= '0;
      smp_err_q   <= 1'b0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef AHB_ARB_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      mwr_q       <= mwr_d;
      mrd_q       <= mrd_d;
      smp_vld_q   <= smp_vld_d;
      smp_rdata_q <= smp_rdata_d;
      smp_err_q   <= smp_err_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef AHB_ARB_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign req_ready       = ready_q;
  assign rsp_valid       = rsp_vld_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_err_q;
  assign busy            = (state_q != ST_IDLE);
  assign m_request_write = mwr_q;
  assign m_request_read  = mrd_q;
  assign m_write_addr    = addr_q;
  assign m_read_addr     = addr_q;
  assign m_write_data    = wdata_q;
`ifdef AHB_ARB_ERR_CNT_EN
  assign err_count       = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// tb_ahb_req_arbiter
//   Self-checking bench for ahb_req_arbiter. A transaction-level reference
//   model predicts, edge by edge, grants, strobes, busy, completion timing and
//   response contents from the round-robin rule and the HREADY history.
//   Build with AHB_ARB_ERR_CNT_EN defined to also check err_count.
module tb_ahb_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic [NR-1:0]      req_valid, req_write;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR-1:0]      req_ready, rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_error, busy;
  logic               m_request_write, m_request_read;
  logic [AW-1:0]      m_write_addr, m_read_addr;
  logic [DW-1:0]      m_write_data, m_read_data;
  logic               m_error_flag, HREADY;
`ifdef AHB_ARB_ERR_CNT_EN
  logic [7:0]         err_count;
`endif

  ahb_req_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .m_request_write (m_request_write),
    .m_request_read  (m_request_read),
    .m_write_addr    (m_write_addr),
    .m_read_addr     (m_read_addr),
    .m_write_data    (m_write_data),
    .m_read_data     (m_read_data),
    .m_error_flag    (m_error_flag),
    .HREADY          (HREADY)
`ifdef AHB_ARB_ERR_CNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  always #5 HCLK = ~HCLK;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int          edge_n = 0;

  // requester agents
  bit            have [NR];
  logic          wr_r [NR];
  logic [AW-1:0] addr_r [NR];
  logic [DW-1:0] wd_r [NR];

  // stimulus knobs
  int unsigned new_pct = 0, hr_pct = 100, err_pct = 0, hr_stall = 0, low_cnt = 0;
  bit          rd_fix_en = 0;
  logic [DW-1:0] rd_fix = '0;
  bit          rst_drv = 0;

  // reference model: one transfer record, times in edge numbers
  bit            m_pend = 0;
  int            m_g = 0, m_e = -1, m_idx = 0, m_last = NR - 1, m_errcnt = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic          m_err = 1'b0;
  bit            x_gnt, x_rsp, x_rst;
  int            x_rsp_idx = 0;

  // observations
  int   q_gnt[$];
  bit   log_en = 0;
  int   ack_edge = 0, rsp_edge = 0;
  logic seen_err = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  task automatic load(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    have[i]   = 1'b1;
    wr_r[i]   = w;
    addr_r[i] = a;
    wd_r[i]   = d;
  endtask

  task automatic drive();
    HRESETn = rst_drv;
    for (int i = 0; i < NR; i++) begin
      if (!have[i] && ($urandom_range(99) < new_pct)) begin
        have[i]   = 1'b1;
        wr_r[i]   = 1'($urandom_range(1));
        addr_r[i] = $urandom;
        wd_r[i]   = $urandom;
      end
      req_valid[i]         = have[i];
      req_write[i]         = wr_r[i];
      req_addr[i*AW +: AW] = addr_r[i];
      req_wdata[i*DW +: DW] = wd_r[i];
    end
    if (low_cnt > 0) begin
      HREADY  = 1'b0;
      low_cnt = low_cnt - 1;
    end else begin
      HREADY = ($urandom_range(99) < hr_pct);
    end
    m_read_data  = rd_fix_en ? rd_fix : DW'($urandom);
    m_error_flag = ($urandom_range(99) < err_pct);
  endtask

  // Advance the reference by one edge using the inputs present at that edge.
  task automatic model();
    x_gnt = 0;
    x_rsp = 0;
    x_rst = 0;
    if (!HRESETn) begin
      x_rst    = 1;
      m_pend   = 0;
      m_last   = NR - 1;
      m_errcnt = 0;
      return;
    end
    if (m_pend && m_e < 0 && edge_n >= m_g + 2 && HREADY) m_e = edge_n;
    if (m_pend && m_e >= 0 && edge_n == m_e + 1) begin
      m_rdata = m_wr ? '0 : m_read_data;
      m_err   = m_error_flag;
      if (m_error_flag && m_errcnt < 255) m_errcnt++;
    end
    if (m_pend && m_e >= 0 && edge_n == m_e + 2) begin
      x_rsp     = 1;
      x_rsp_idx = m_idx;
      m_pend    = 0;
    end
    if (!m_pend && req_valid != '0) begin
      int pick = -1;
      for (int o = 1; o <= NR; o++) begin
        int c = (m_last + o) % NR;
        if (pick < 0 && req_valid[c]) pick = c;
      end
      x_gnt   = 1;
      m_pend  = 1;
      m_g     = edge_n;
      m_e     = -1;
      m_idx   = pick;
      m_last  = pick;
      m_wr    = req_write[pick];
      m_addr  = req_addr[pick*AW +: AW];
      m_wdata = req_wdata[pick*DW +: DW];
    end
  endtask

  task automatic compare();
    logic [NR-1:0] xr, xv;
    logic          xb;
    xr = x_gnt ? (NR'(1) << m_idx) : '0;
    xv = x_rsp ? (NR'(1) << x_rsp_idx) : '0;
    xb = m_pend && (m_e < 0 || edge_n <= m_e);
    chk_eq("req_ready", req_ready, xr);
    chk_eq("m_request_write", m_request_write, x_gnt && m_wr);
    chk_eq("m_request_read", m_request_read, x_gnt && !m_wr);
    chk_eq("busy", busy, xb);
    chk_eq("rsp_valid", rsp_valid, xv);
    if (x_rsp) begin
      chk_eq("rsp_rdata", rsp_rdata, m_rdata);
      chk_eq("rsp_error", rsp_error, m_err);
    end
    if (xb) begin
      chk_eq("m_write_addr", m_write_addr, m_addr);
      chk_eq("m_read_addr", m_read_addr, m_addr);
      chk_eq("m_write_data", m_write_data, m_wdata);
    end
    if (x_rst) begin
      chk_eq("rst_rsp_rdata", rsp_rdata, 0);
      chk_eq("rst_rsp_error", rsp_error, 0);
      chk_eq("rst_m_write_addr", m_write_addr, 0);
      chk_eq("rst_m_read_addr", m_read_addr, 0);
      chk_eq("rst_m_write_data", m_write_data, 0);
    end
`ifdef AHB_ARB_ERR_CNT_EN
    chk_eq("err_count", err_count, m_errcnt);
`endif
  endtask

  task automatic cycle();
    @(negedge HCLK);
    drive();
    @(posedge HCLK);
    edge_n++;
    #1;
    model();
    compare();
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] === 1'b1) begin
        have[i]  = 1'b0;
        ack_edge = edge_n;
        if (log_en) q_gnt.push_back(i);
        if (hr_stall > 0) low_cnt = hr_stall + 1;
      end
    end
    if (rsp_valid !== '0) begin
      rsp_edge = edge_n;
      seen_err = rsp_error;
    end
  endtask

  initial begin
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    HRESETn      = 1'b1;
    req_valid    = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    HREADY       = 1'b1;
    m_read_data  = '0;
    m_error_flag = 1'b0;
    for (int i = 0; i < NR; i++) begin
      have[i] = 0; wr_r[i] = 0; addr_r[i] = '0; wd_r[i] = '0;
    end

    // reset state
    rst_drv = 0;
    repeat (3) cycle();
    rst_drv = 1;

    // single read from requester 0
    rd_fix_en = 1;
    rd_fix    = 32'hA5A5_0001;
    load(0, 1'b0, 32'h0000_0100, 32'h0);
    repeat (8) cycle();
    chk_eq("read_latency", rsp_edge - ack_edge, 4);
    rd_fix_en = 0;

    // write from requester 2 with three wait states
    hr_stall = 3;
    load(2, 1'b1, 32'h0000_0200, 32'h0000_1234);
    repeat (10) cycle();
    chk_eq("wait_latency", rsp_edge - ack_edge, 7);
    hr_stall = 0;

    // error response on requester 3
    err_pct = 100;
    load(3, 1'b0, 32'h0000_0300, 32'h0);
    repeat (6) cycle();
    err_pct = 0;
    chk_eq("err_flag", seen_err, 1);
`ifdef AHB_ARB_ERR_CNT_EN
    chk_eq("err_count_one", err_count, 1);
`endif

    // fairness with every requester always requesting
    q_gnt.delete();
    log_en  = 1;
    new_pct = 100;
    repeat (22) cycle();
    log_en  = 0;
    new_pct = 0;
    chk_eq("fair_grants", q_gnt.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < q_gnt.size()) chk_eq("fair_order", q_gnt[i], exp_ord[i]);
    end
    repeat (24) cycle();

`ifdef AHB_ARB_ERR_CNT_EN
    // counter saturation
    err_pct = 100;
    new_pct = 100;
    repeat (1250) cycle();
    new_pct = 0;
    repeat (24) cycle();
    err_pct = 0;
    chk_eq("err_count_sat", err_count, 255);
`endif

    // reset while waiting on HREADY
    hr_stall = 10;
    load(1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF);
    repeat (3) cycle();
    chk_eq("in_wait_busy", busy, 1);
    hr_stall = 0;
    low_cnt  = 0;
    rst_drv  = 0;
    load(0, 1'b0, 32'h0000_0040, 32'h0);
    load(2, 1'b1, 32'h0000_0080, 32'h0000_0055);
    q_gnt.delete();
    log_en = 1;
    repeat (2) cycle();
    rst_drv = 1;
    repeat (10) cycle();
    log_en = 0;
    chk_eq("post_reset_first", (q_gnt.size() > 0) ? q_gnt[0] : -1, 0);
    repeat (10) cycle();

    // randomized traffic with one mid-run reset
    new_pct = 35;
    hr_pct  = 70;
    err_pct = 20;
    for (int t = 0; t < 600; t++) begin
      if (t == 300) begin
        rst_drv = 0;
        low_cnt = 0;
        repeat (2) cycle();
        rst_drv = 1;
      end
      if (t % 97 == 0) hr_stall = $urandom_range(4);
      cycle();
    end
    new_pct  = 0;
    hr_stall = 0;
    hr_pct   = 100;
    repeat (30) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
